// File: rtl/fp_addsub_arbiter.sv
// rtl/fp_addsub_arbiter.sv - two-port round-robin front end for a shared pipelined FP add/sub unit
// Credits per port bound in-flight plus buffered results so the response FIFOs can never overflow.
module fp_addsub_arbiter #(
  parameter int WIDTH      = 32,
  parameter int LATENCY    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             unit_valid,
  output logic [WIDTH-1:0] unit_a,
  output logic [WIDTH-1:0] unit_b,
  output logic             unit_op,
  input  logic [WIDTH-1:0] unit_result
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CREDIT = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_SLOT   = PW'(FIFO_DEPTH - 1);

  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [1:0]         rsp_valid;
  logic [1:0]         rsp_ready;
  logic [1:0]         eligible;
  logic [1:0]         hs;
  logic [1:0]         push;
  logic [1:0]         pop;
  logic               grant_any;
  logic               grant_port;
  logic               rr_last;
  logic               unit_port;
  logic [LATENCY-1:0] tag_valid;
  logic [LATENCY-1:0] tag_port;
  logic [CW-1:0]      credit [2];
  logic [CW-1:0]      count  [2];
  logic [PW-1:0]      wr_ptr [2];
  logic [PW-1:0]      rd_ptr [2];
  logic [WIDTH-1:0]   mem    [2][FIFO_DEPTH];

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + PW'(1);
  endfunction

  assign req_valid  = {req1_valid, req0_valid};
  assign rsp_ready  = {rsp1_ready, rsp0_ready};
  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];
  assign rsp0_valid = rsp_valid[0];
  assign rsp1_valid = rsp_valid[1];
  assign rsp0_result = mem[0][rd_ptr[0]];
  assign rsp1_result = mem[1][rd_ptr[1]];

  // Grant goes to the port that did not win last time when both are eligible.
  always_comb begin
    eligible   = 2'b00;
    req_ready  = 2'b00;
    eligible[0] = req_valid[0] && (credit[0] != '0);
    eligible[1] = req_valid[1] && (credit[1] != '0);
    grant_any  = rst_n && (eligible != 2'b00);
    grant_port = (eligible == 2'b11) ? ~rr_last : eligible[1];
    if (grant_any) begin
      req_ready[grant_port] = 1'b1;
    end
  end

  always_comb begin
    hs   = req_valid & req_ready;
    push = 2'b00;
    pop  = 2'b00;
    for (int n = 0; n < 2; n++) begin
      rsp_valid[n] = rst_n && (count[n] != '0);
      push[n]      = tag_valid[LATENCY-1] && (tag_port[LATENCY-1] == n[0]);
      pop[n]       = rsp_valid[n] && rsp_ready[n];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      unit_valid <= 1'b0;
      unit_a     <= '0;
      unit_b     <= '0;
      unit_op    <= 1'b0;
      unit_port  <= 1'b0;
      rr_last    <= 1'b1;
    end else begin
      unit_valid <= grant_any;
      if (grant_any) begin
        unit_a    <= grant_port ? req1_a  : req0_a;
        unit_b    <= grant_port ? req1_b  : req0_b;
        unit_op   <= grant_port ? req1_op : req0_op;
        unit_port <= grant_port;
        rr_last   <= grant_port;
      end
    end
  end

  // Tag stage LATENCY-1 lines up with the cycle in which unit_result is valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_valid <= '0;
      tag_port  <= '0;
    end else begin
      tag_valid[0] <= unit_valid;
      tag_port[0]  <= unit_port;
      for (int i = 1; i < LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_port[i]  <= tag_port[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (!rst_n) begin
        credit[n] <= FULL_CREDIT;
        count[n]  <= '0;
        wr_ptr[n] <= '0;
        rd_ptr[n] <= '0;
      end else begin
        case ({hs[n], pop[n]})
          2'b10:   credit[n] <= credit[n] - CW'(1);
          2'b01:   credit[n] <= credit[n] + CW'(1);
          default: credit[n] <= credit[n];
        endcase
        case ({push[n], pop[n]})
          2'b10:   count[n] <= count[n] + CW'(1);
          2'b01:   count[n] <= count[n] - CW'(1);
          default: count[n] <= count[n];
        endcase
        if (push[n]) begin
          wr_ptr[n] <= next_ptr(wr_ptr[n]);
        end
        if (pop[n]) begin
          rd_ptr[n] <= next_ptr(rd_ptr[n]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (push[n]) begin
        mem[n][wr_ptr[n]] <= unit_result;
      end
    end
  end

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// tb/tb_fp_addsub_arbiter.sv - scoreboard bench for fp_addsub_arbiter with a pipelined unit model
// Reference tracks outstanding work per port and expected results in per-port queues.
module tb_fp_addsub_arbiter;
  localparam int W   = 32;
  localparam int LAT = 3;
  localparam int DEP = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req0_op;
  logic         req1_valid, req1_ready, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [W-1:0] rsp0_result, rsp1_result;
  logic         unit_valid, unit_op;
  logic [W-1:0] unit_a, unit_b, unit_result;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q0 [$];
  logic [W-1:0] exp_q1 [$];
  int outst [2];
  int rr_m;
  logic me0, me1;
  logic [1:0] m_want;
  int lat, got, r1seen, prev, cur, n0, n1, popped, resumed, stale;

  always #5 clk = ~clk;

  fp_addsub_arbiter #(.WIDTH(W), .LATENCY(LAT), .FIFO_DEPTH(DEP)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .unit_valid(unit_valid), .unit_a(unit_a), .unit_b(unit_b), .unit_op(unit_op),
    .unit_result(unit_result)
  );

  function automatic logic [W-1:0] unit_fn(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
    return op ? (a - b) : (a + b);
  endfunction

  // Shared unit: result valid LAT cycles after the unit_valid cycle.
  logic         pv [LAT];
  logic [W-1:0] pa [LAT];
  logic [W-1:0] pb [LAT];
  logic         po [LAT];
  always @(posedge clk) begin
    pv[0] <= unit_valid;
    pa[0] <= unit_a;
    pb[0] <= unit_b;
    po[0] <= unit_op;
    for (int i = 1; i < LAT; i++) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
      pb[i] <= pb[i-1];
      po[i] <= po[i-1];
    end
  end
  assign unit_result = (pv[LAT-1] === 1'b1) ? unit_fn(pa[LAT-1], pb[LAT-1], po[LAT-1]) : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic rand_ops();
    req0_a  = $urandom();
    req0_b  = $urandom();
    req0_op = 1'($urandom_range(0, 1));
    req1_a  = $urandom();
    req1_b  = $urandom();
    req1_op = 1'($urandom_range(0, 1));
  endtask

  task automatic drain(input string name);
    int i;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    i = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0 || rsp0_valid || rsp1_valid) && i < 200) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk(name, 64'(exp_q0.size() + exp_q1.size()), 0);
  endtask

  // Monitor: readiness model from outstanding counts, scoreboard on every pop.
  initial begin
    outst[0] = 0;
    outst[1] = 0;
    rr_m = 1;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        exp_q0.delete();
        exp_q1.delete();
        outst[0] = 0;
        outst[1] = 0;
        rr_m = 1;
      end else begin
        me0 = req0_valid && (outst[0] < DEP);
        me1 = req1_valid && (outst[1] < DEP);
        m_want = 2'b00;
        if (me0 && me1) m_want = (rr_m == 1) ? 2'b01 : 2'b10;
        else if (me0) m_want = 2'b01;
        else if (me1) m_want = 2'b10;
        chk("ready", {req1_ready, req0_ready}, m_want);
        if (req0_valid && req0_ready) begin
          exp_q0.push_back(unit_fn(req0_a, req0_b, req0_op));
          outst[0]++;
          rr_m = 0;
        end
        if (req1_valid && req1_ready) begin
          exp_q1.push_back(unit_fn(req1_a, req1_b, req1_op));
          outst[1]++;
          rr_m = 1;
        end
        if (rsp0_valid && rsp0_ready) begin
          if (exp_q0.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rsp0_unexpected: got %0h want none", rsp0_result);
          end else begin
            chk("rsp0_data", rsp0_result, exp_q0.pop_front());
          end
          if (outst[0] > 0) outst[0]--;
        end
        if (rsp1_valid && rsp1_ready) begin
          if (exp_q1.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rsp1_unexpected: got %0h want none", rsp1_result);
          end else begin
            chk("rsp1_data", rsp1_result, exp_q1.pop_front());
          end
          if (outst[1] > 0) outst[1]--;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    rand_ops();
    repeat (3) @(posedge clk);
    #1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    chk("rst_ready", {req1_ready, req0_ready}, 2'b00);
    chk("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 2'b00);
    chk("rst_unit_valid", unit_valid, 0);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b1;

    // Single add and its latency
    @(posedge clk);
    #1;
    req0_a = 32'h3F80_0000;
    req0_b = 32'h4000_0000;
    req0_op = 1'b0;
    req0_valid = 1'b1;
    @(negedge clk);
    chk("single_ready", req0_ready, 1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    lat = 0;
    got = 0;
    r1seen = 0;
    while (got == 0 && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        chk("single_unit_valid", unit_valid, 1);
        chk("single_unit_a", unit_a, 32'h3F80_0000);
        chk("single_unit_b", unit_b, 32'h4000_0000);
        chk("single_unit_op", unit_op, 0);
      end
      if (lat == 2) chk("single_unit_idle", unit_valid, 0);
      if (rsp1_valid) r1seen = 1;
      if (rsp0_valid) begin
        got = 1;
        chk("single_result", rsp0_result, unit_fn(32'h3F80_0000, 32'h4000_0000, 1'b0));
      end
    end
    chk("single_latency", lat, LAT + 2);
    chk("single_rsp1_quiet", r1seen, 0);
    drain("drain_single");

    // Contention: alternating grants, unit busy every cycle
    @(posedge clk);
    #1;
    rand_ops();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    prev = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      cur = req1_ready ? 1 : 0;
      chk("cont_one_ready", req0_ready ^ req1_ready, 1);
      if (i > 0) begin
        chk("cont_alternate", cur, 1 - prev);
        chk("cont_unit_valid", unit_valid, 1);
      end
      prev = cur;
      @(posedge clk);
      #1;
      rand_ops();
    end
    drain("drain_cont");

    // Backpressure on port 1
    @(posedge clk);
    #1;
    rsp1_ready = 1'b0;
    rsp0_ready = 1'b1;
    rand_ops();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (req1_valid && req1_ready) n1++;
      if (req0_valid && req0_ready) n0++;
      if (i >= 16) chk("bp_req1_blocked", req1_ready, 0);
      @(posedge clk);
      #1;
      rand_ops();
    end
    chk("bp_port1_count", n1, DEP);
    chk("bp_port0_flow", (n0 >= 12) ? 1 : 0, 1);
    rsp1_ready = 1'b1;
    popped = 0;
    resumed = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp1_valid && rsp1_ready) popped++;
      if (req1_valid && req1_ready) resumed = 1;
      @(posedge clk);
      #1;
      rand_ops();
    end
    chk("bp_resume", resumed, 1);
    chk("bp_drained", (popped >= DEP) ? 1 : 0, 1);
    drain("drain_bp");

    // Reset with three results in flight
    @(posedge clk);
    #1;
    rand_ops();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      rand_ops();
    end
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < LAT + 6; i++) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid) stale++;
    end
    chk("rst_no_stale", stale, 0);
    @(posedge clk);
    #1;
    rand_ops();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    chk("rst_first_grant", {req1_ready, req0_ready}, 2'b01);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    rsp1_ready = 1'b0;
    n1 = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (req1_valid && req1_ready) n1++;
      @(posedge clk);
      #1;
      rand_ops();
    end
    chk("rst_credit1", n1, DEP);
    drain("drain_rst");

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      rand_ops();
      req0_valid = ($urandom_range(0, 9) < 7);
      req1_valid = ($urandom_range(0, 9) < 7);
      rsp0_ready = ($urandom_range(0, 9) < 6);
      rsp1_ready = ($urandom_range(0, 9) < 6);
    end
    drain("drain_rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
